// File: rtl/fp_addsub_seq_if.sv
// fp_addsub_seq_if: operand/result valid-ready bundle for the sequential float adder
interface fp_addsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) ();
  localparam int W = 1 + EXP_W + MAN_W;
  logic in_valid, in_ready, op_sub, out_valid, out_ready, flag_ovf, flag_unf, flag_inv;
  logic [W-1:0] a, b, result;
  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
  );
  modport slave (
    input in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inv
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle float add/sub with RNE rounding, flush-to-zero and special-case flags
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic reset,
  fp_addsub_seq_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 5;
  localparam int E = EXP_W + 2;
  localparam logic [2:0] IDLE = 3'd0, ALIGN = 3'd1, ADD = 3'd2, NORM = 3'd3, ROUND = 3'd4, DONE = 3'd5;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [M-1:0] HID = {2'b01, {(MAN_W+3){1'b0}}};

  logic [2:0] state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, spec_res_q, spec_res_d, result_q, result_d;
  logic sx_q, sx_d, esub_q, esub_d, spec_q, spec_d, spec_inv_q, spec_inv_d;
  logic ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
  logic signed [E-1:0] exp_q, exp_d;
  logic [M-1:0] mx_q, mx_d, my_q, my_d, m_q, m_d;

  logic [EXP_W-1:0] ea, eb, ex, ey, dexp;
  logic nan_a, nan_b, inf_a, inf_b, swap, is_spec, spec_iv;
  logic [W-1:0] x, y, spec_val;
  logic [M-1:0] mx0, my0, ysh;

  // unpack captured operands: order by magnitude, align the smaller one with sticky, classify specials
  always_comb begin
    ea = a_q[W-2:MAN_W];
    eb = b_q[W-2:MAN_W];
    nan_a = ea == EMAX && a_q[MAN_W-1:0] != '0;
    nan_b = eb == EMAX && b_q[MAN_W-1:0] != '0;
    inf_a = ea == EMAX && a_q[MAN_W-1:0] == '0;
    inf_b = eb == EMAX && b_q[MAN_W-1:0] == '0;
    swap = (eb == '0 ? {(W-1){1'b0}} : b_q[W-2:0]) > (ea == '0 ? {(W-1){1'b0}} : a_q[W-2:0]);
    x = swap ? b_q : a_q;
    y = swap ? a_q : b_q;
    ex = x[W-2:MAN_W];
    ey = y[W-2:MAN_W];
    mx0 = ex == '0 ? '0 : {2'b01, x[MAN_W-1:0], 3'b000};
    my0 = ey == '0 ? '0 : {2'b01, y[MAN_W-1:0], 3'b000};
    dexp = ex - ey;
    ysh = dexp > EXP_W'(MAN_W + 3) ? {{(M-1){1'b0}}, |my0}
        : (my0 >> dexp) | {{(M-1){1'b0}}, |(my0 & ~({M{1'b1}} << dexp))};
    is_spec = nan_a | nan_b | inf_a | inf_b;
    spec_iv = nan_a | nan_b | (inf_a & inf_b & (a_q[W-1] ^ b_q[W-1]));
    spec_val = spec_iv ? QNAN : inf_a ? a_q : b_q;
  end

  logic [MAN_W+1:0] rsum;
  logic [MAN_W-1:0] rman;
  logic signed [E-1:0] rexp;
  logic rinc, rzero, rovf, runf;
  logic [W-1:0] rres;

  // round-to-nearest-even on the normalised mantissa, then range-check the exponent
  always_comb begin
    rinc = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    rsum = {1'b0, m_q[M-2:3]} + (MAN_W+2)'(rinc);
    rman = rsum[MAN_W+1] ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
    rexp = exp_q + E'(rsum[MAN_W+1]);
    rzero = m_q == '0;
    rovf = !spec_q && !rzero && !rexp[E-1] && rexp[E-2:0] >= {1'b0, EMAX};
    runf = !spec_q && !rzero && !rovf && (rexp[E-1] || rexp == '0);
    rres = spec_q ? spec_res_q
         : rzero ? {sx_q & !esub_q, {(W-1){1'b0}}}
         : rovf ? {sx_q, EMAX, {MAN_W{1'b0}}}
         : runf ? {sx_q, {(W-1){1'b0}}}
         : {sx_q, rexp[EXP_W-1:0], rman};
  end

  // sequencer: one operation walks IDLE/ALIGN/ADD/NORM/ROUND/DONE; specials ride through with a fixed mantissa
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sx_d = sx_q;
    esub_d = esub_q;
    spec_d = spec_q;
    spec_res_d = spec_res_q;
    spec_inv_d = spec_inv_q;
    exp_d = exp_q;
    mx_d = mx_q;
    my_d = my_q;
    m_d = m_q;
    result_d = result_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    inv_d = inv_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        a_d = io.a;
        b_d = {io.b[W-1] ^ io.op_sub, io.b[W-2:0]};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inv_d = 1'b0;
        state_d = ALIGN;
      end
      ALIGN: begin
        sx_d = x[W-1];
        esub_d = !is_spec && (x[W-1] ^ y[W-1]);
        exp_d = E'(ex);
        mx_d = is_spec ? HID : mx0;
        my_d = is_spec ? '0 : ysh;
        spec_d = is_spec;
        spec_res_d = spec_val;
        spec_inv_d = spec_iv;
        state_d = ADD;
      end
      ADD: begin
        m_d = esub_q ? mx_q - my_q : mx_q + my_q;
        state_d = NORM;
      end
      NORM: if (m_q[M-1]) begin
        m_d = {1'b0, m_q[M-1:2], m_q[1] | m_q[0]};
        exp_d = exp_q + 1'b1;
        state_d = ROUND;
      end else if (!m_q[M-2] && m_q != '0) begin
        m_d = m_q << 1;
        exp_d = exp_q - 1'b1;
      end else begin
        state_d = ROUND;
      end
      ROUND: begin
        result_d = rres;
        ovf_d = rovf;
        unf_d = runf;
        inv_d = spec_q & spec_inv_q;
        state_d = DONE;
      end
      DONE: state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset aborts any operation in flight and clears the result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sx_q <= 1'b0;
      esub_q <= 1'b0;
      spec_q <= 1'b0;
      spec_res_q <= '0;
      spec_inv_q <= 1'b0;
      exp_q <= '0;
      mx_q <= '0;
      my_q <= '0;
      m_q <= '0;
      result_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sx_q <= sx_d;
      esub_q <= esub_d;
      spec_q <= spec_d;
      spec_res_q <= spec_res_d;
      spec_inv_q <= spec_inv_d;
      exp_q <= exp_d;
      mx_q <= mx_d;
      my_q <= my_d;
      m_q <= m_d;
      result_q <= result_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inv_q <= inv_d;
    end
  end

  assign io.in_ready = state_q == IDLE;
  assign io.out_valid = state_q == DONE;
  assign io.result = result_q;
  assign io.flag_ovf = ovf_q;
  assign io.flag_unf = unf_q;
  assign io.flag_inv = inv_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: scoreboard bench for fp_addsub_seq against an exact-arithmetic reference
module tb_fp_addsub_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) io ();
  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .reset(reset), .io(io));

  typedef struct {
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit seen = 0;
  bit have_cur = 0;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0, stall = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // exact sum as a scaled integer, then a single RNE rounding to 24 significant bits
  function automatic exp_t model(logic [31:0] a, logic [31:0] b0, bit sub, int lat);
    exp_t e;
    logic [31:0] b;
    int ea, eb, lo, p, sh, ex;
    logic [23:0] ma, mb;
    logic signed [127:0] xa, xb, s;
    logic [127:0] mag, q, rem, half;
    b = {b0[31] ^ sub, b0[30:0]};
    e.lat = lat;
    e.fl = 3'b000;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) begin
      e.res = 32'h7FC00000;
      e.fl = 3'b001;
      return e;
    end
    if (ea == 255 && eb == 255) begin
      e.res = (a[31] != b[31]) ? 32'h7FC00000 : a;
      e.fl = {2'b00, a[31] != b[31]};
      return e;
    end
    if (ea == 255) begin e.res = a; return e; end
    if (eb == 255) begin e.res = b; return e; end
    ma = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
    mb = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
    if (ma == 0) ea = eb;
    if (mb == 0) eb = ea;
    lo = (ea < eb) ? ea : eb;
    if (ea - lo > 60) begin
      lo = ea - 60;
      xa = 128'(ma) << 60;
      xb = 128'(mb != 0);
    end else if (eb - lo > 60) begin
      lo = eb - 60;
      xb = 128'(mb) << 60;
      xa = 128'(ma != 0);
    end else begin
      xa = 128'(ma) << (ea - lo);
      xb = 128'(mb) << (eb - lo);
    end
    s = (a[31] ? -xa : xa) + (b[31] ? -xb : xb);
    if (s == 0) begin
      e.res = {a[31] & b[31], 31'b0};
      return e;
    end
    mag = (s < 0) ? -s : s;
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    sh = p - 23;
    if (p > 23) begin
      q = mag >> sh;
      rem = mag - (q << sh);
      half = 128'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q[24]) begin
        q = q >> 1;
        sh++;
      end
    end else begin
      q = mag << (23 - p);
    end
    ex = lo + sh;
    if (ex >= 255) begin
      e.res = {s < 0, 8'hFF, 23'b0};
      e.fl = 3'b100;
    end else if (ex <= 0) begin
      e.res = {s < 0, 31'b0};
      e.fl = 3'b010;
    end else begin
      e.res = {s < 0, 8'(ex), q[22:0]};
    end
    return e;
  endfunction

  // consumer side: random backpressure, with a forced run of low cycles when requested
  always @(negedge clk) begin
    if (io.out_valid && stall > 0) begin
      io.out_ready = 1'b0;
      stall--;
    end else begin
      io.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: pop on the first valid cycle, then insist the output stays put until taken
  always @(negedge clk) begin
    if (reset) begin
      seen = 0;
    end else if (io.out_valid) begin
      if (!seen) begin
        seen = 1;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          have_cur = 0;
          $display("FAIL unexpected_output: got %h expected no output", io.result);
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          check("result", 64'(io.result), 64'(cur.res));
          check("flags", 64'({io.flag_ovf, io.flag_unf, io.flag_inv}), 64'(cur.fl));
          if (cur.lat >= 0) check("latency", 64'(cyc - acc_cyc), 64'(cur.lat));
        end
      end else if (have_cur) begin
        check("held_result", 64'(io.result), 64'(cur.res));
        check("held_flags", 64'({io.flag_ovf, io.flag_unf, io.flag_inv}), 64'(cur.fl));
      end
    end else begin
      seen = 0;
    end
  end

  task automatic issue(logic [31:0] a, logic [31:0] b, bit sub, int lat, bit chk);
    int t = 0;
    @(negedge clk);
    while (!io.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 64'(io.in_ready), 64'd1);
    io.a = a;
    io.b = b;
    io.op_sub = sub;
    io.in_valid = 1'b1;
    if (chk) sb.push_back(model(a, b, sub, lat));
    acc_cyc = cyc + 1;
    @(negedge clk);
    io.in_valid = 1'b0;
    io.a = $urandom;
    io.b = $urandom;
    io.op_sub = 1'($urandom_range(0, 1));
    if (chk) begin
      t = 0;
      while (sb.size() != 0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  logic [31:0] da[12] = '{32'h3FC00000, 32'hC0400000, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h7F7FFFFF,
                          32'h7F800000, 32'h3F800001, 32'h80000000, 32'h7F800001, 32'hFF800000, 32'h00800000};
  logic [31:0] db[12] = '{32'h40200000, 32'h3F800000, 32'h3F800000, 32'h33800000, 32'h33800000, 32'h7F7FFFFF,
                          32'h7F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000, 32'h00800001};
  bit ds[12] = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1};
  int dl[12] = '{4, 4, 4, -1, -1, 4, 4, 27, -1, 4, 4, -1};

  initial begin
    logic [31:0] ra, rb;
    int e2;
    io.in_valid = 1'b0;
    io.op_sub = 1'b0;
    io.a = '0;
    io.b = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(io.in_ready), 64'd1);
    check("rst_out_valid", 64'(io.out_valid), 64'd0);
    check("rst_result", 64'(io.result), 64'd0);
    check("rst_flags", 64'({io.flag_ovf, io.flag_unf, io.flag_inv}), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) issue(da[i], db[i], ds[i], dl[i], 1'b1);
    stall = 5;
    issue(32'h40400000, 32'h40000000, 1'b0, 4, 1'b1);
    issue(32'h3F800001, 32'h3F800000, 1'b1, -1, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(io.in_ready), 64'd1);
    check("midrst_out_valid", 64'(io.out_valid), 64'd0);
    check("midrst_result", 64'(io.result), 64'd0);
    reset = 1'b0;
    issue(32'h3FC00000, 32'h40200000, 1'b0, 4, 1'b1);
    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: begin
          e2 = int'(ra[30:23]) + int'($urandom_range(0, 6)) - 3;
          e2 = (e2 < 0) ? 0 : (e2 > 255) ? 255 : e2;
          rb = {1'($urandom_range(0, 1)), 8'(e2), 23'($urandom)};
        end
        2: rb = ra ^ 32'($urandom_range(0, 255));
        3: rb = {1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                 ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom)};
        default: begin
          ra = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 4)), 23'($urandom)};
          rb = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 4)), 23'($urandom)};
        end
      endcase
      issue(ra, rb, 1'($urandom_range(0, 1)), -1, 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end
endmodule
